osd_spi_master: RTL and testbench

- FPGA-side SPI master that drives the OSD SPI channel (SPI_SCK / SPI_SS3 / SPI_DI) consumed by the video mixer's OSD.
- Used on boards with no ARM controller (zx1), so a local controller can enable or disable the OSD and upload OSD bitmap lines.
- Byte payload is pulled from a local bitmap RAM through a read port with 1-cycle latency.

---
 rtl/osd_spi_pkg.sv | 30 +++
 rtl/spi_byte_shifter.sv | 77 +++++++
 rtl/osd_spi_master.sv | 169 ++++++++++++++++
 tb/tb_osd_spi_master.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/osd_spi_pkg.sv
// Shared definitions for the OSD SPI master.
// Holds the operation codes presented on the op port, the command bytes the
// OSD expects for each operation, the controller state encoding, and a helper
// that maps an operation and line number onto the command byte.
package osd_spi_pkg;

  localparam logic [1:0] OP_DISABLE  = 2'd0;
  localparam logic [1:0] OP_ENABLE   = 2'd1;
  localparam logic [1:0] OP_WRITE    = 2'd2;
  localparam logic [1:0] OP_RESERVED = 2'd3;

  localparam logic [7:0] CMD_OSD_DISABLE = 8'h40;
  localparam logic [7:0] CMD_OSD_ENABLE  = 8'h41;
  localparam logic [7:0] CMD_WRITE_BASE  = 8'h20;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  function automatic logic [7:0] cmd_byte(input logic [1:0] op, input logic [3:0] line);
    case (op)
      OP_DISABLE: return CMD_OSD_DISABLE;
      OP_ENABLE:  return CMD_OSD_ENABLE;
      default:    return CMD_WRITE_BASE | {4'h0, line};
    endcase
  endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// Serialises one byte at a time, MSB first, onto SCK/DI.
// Each bit is CLK_DIV cycles with SCK low followed by CLK_DIV cycles with SCK
// high; DI changes only on the first low cycle of a bit. Asserting load on the
// byte_done cycle chains the next byte with no idle SCK period in between.
// Ports:
//   clk_sys    system clock
//   reset      synchronous active-high reset (stops shifting)
//   load       start shifting load_data on the next cycle
//   load_data  byte to shift
//   byte_done  last cycle of bit 7 high phase
//   bit0_start first cycle of bit 0 low phase
//   sck, di    serial clock and data (both low when idle)
module spi_byte_shifter #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_data,
  output logic       byte_done,
  output logic       bit0_start,
  output logic       sck,
  output logic       di
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic             active;
  logic             phase_hi;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             div_wrap;

  assign div_wrap = (div_cnt == DIV_LAST);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      active   <= 1'b0;
      phase_hi <= 1'b0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
    end else if (load) begin
      active   <= 1'b1;
      phase_hi <= 1'b0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
    end else if (active) begin
      if (div_wrap) begin
        div_cnt  <= '0;
        phase_hi <= ~phase_hi;
        if (phase_hi) begin
          // bit counter wraps 7 -> 0; without a reload the byte ends here
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) active <= 1'b0;
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (load) begin
      shreg <= load_data;
    end else if (active && div_wrap && phase_hi) begin
      shreg <= {shreg[6:0], 1'b0};
    end
  end

  assign sck        = active & phase_hi;
  assign di         = active & shreg[7];
  assign bit0_start = active & ~phase_hi & (div_cnt == '0) & (bit_cnt == 3'd0);
  assign byte_done  = active & phase_hi & div_wrap & (bit_cnt == 3'd7);

endmodule

// File: rtl/osd_spi_master.sv
// FPGA-side SPI master for the OSD channel of the video mixer.
// Sends OSD enable/disable commands and OSD line writes (command byte plus
// LINE_BYTES payload bytes pulled from a bitmap RAM with 1-cycle read latency).
// Ports:
//   clk_sys    system clock
//   reset      synchronous active-high reset; aborts any transaction
//   req        start strobe, honoured only when idle and op != 3
//   op, line   operation and OSD line number, latched on accept
//   busy       transaction in progress
//   done       one-cycle pulse on the final cycle of a transaction
//   data_rd    payload read strobe
//   data_addr  payload byte index
//   data_in    payload byte, valid the cycle after data_rd
//   SPI_SCK, SPI_SS3, SPI_DI  OSD SPI interface
module osd_spi_master import osd_spi_pkg::*; #(
  parameter int CLK_DIV    = 4,
  parameter int LINE_BYTES = 256,
  parameter int SS_SETUP   = 2,
  parameter int SS_HOLD    = 2,
  parameter int SS_GAP     = 4
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       req,
  input  logic [1:0] op,
  input  logic [3:0] line,
  output logic       busy,
  output logic       done,
  output logic       data_rd,
  output logic [7:0] data_addr,
  input  logic [7:0] data_in,
  output logic       SPI_SCK,
  output logic       SPI_SS3,
  output logic       SPI_DI
);

  localparam int CNT_MAX = (SS_SETUP > SS_HOLD) ?
                           ((SS_SETUP > SS_GAP) ? SS_SETUP : SS_GAP) :
                           ((SS_HOLD > SS_GAP) ? SS_HOLD : SS_GAP);
  localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(SS_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(SS_GAP - 1);
  localparam logic [8:0]       WRITE_LAST = 9'(LINE_BYTES);

  logic [2:0]       state;
  logic [CNT_W-1:0] phase_cnt;
  logic [8:0]       byte_cnt;
  logic [1:0]       op_q;
  logic [3:0]       line_q;
  logic             accept;
  logic             is_write;
  logic             last_byte;
  logic             sh_load;
  logic [7:0]       sh_data;
  logic             byte_done;
  logic             bit0_start;
  logic             rd_vld_p1;
  logic [7:0]       payload_p1;

  assign accept    = (state == ST_IDLE) && req && (op != OP_RESERVED);
  assign is_write  = (op_q == OP_WRITE);
  assign last_byte = is_write ? (byte_cnt == WRITE_LAST) : (byte_cnt == 9'd0);

  // Command byte goes out after setup; each payload byte is loaded exactly at
  // the previous byte's boundary so SCK runs without a gap.
  always_comb begin
    sh_load = 1'b0;
    sh_data = payload_p1;
    if (state == ST_SETUP && phase_cnt == SETUP_LAST) begin
      sh_load = 1'b1;
      sh_data = cmd_byte(op_q, line_q);
    end else if (state == ST_SHIFT && byte_done && !last_byte) begin
      sh_load = 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= ST_IDLE;
      phase_cnt <= '0;
      byte_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state     <= ST_SETUP;
            phase_cnt <= '0;
            byte_cnt  <= '0;
          end
        end
        ST_SETUP: begin
          if (phase_cnt == SETUP_LAST) begin
            state     <= ST_SHIFT;
            phase_cnt <= '0;
          end else begin
            phase_cnt <= phase_cnt + CNT_W'(1);
          end
        end
        ST_SHIFT: begin
          if (byte_done) begin
            if (last_byte) begin
              state     <= ST_HOLD;
              phase_cnt <= '0;
            end else begin
              byte_cnt <= byte_cnt + 9'd1;
            end
          end
        end
        ST_HOLD: begin
          if (phase_cnt == HOLD_LAST) begin
            state     <= ST_GAP;
            phase_cnt <= '0;
          end else begin
            phase_cnt <= phase_cnt + CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (phase_cnt == GAP_LAST) begin
            state     <= ST_IDLE;
            phase_cnt <= '0;
          end else begin
            phase_cnt <= phase_cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (accept) begin
      op_q   <= op;
      line_q <= line;
    end
  end

  // Prefetch byte n while byte n-1 (the command byte for n = 0) shifts out.
  assign data_rd   = (state == ST_SHIFT) && is_write && bit0_start && !last_byte;
  assign data_addr = byte_cnt[7:0];

  // p0 -> p1: RAM data returns one cycle after the read strobe
  always_ff @(posedge clk_sys) begin
    if (reset) rd_vld_p1 <= 1'b0;
    else       rd_vld_p1 <= data_rd;
  end

  always_ff @(posedge clk_sys) begin
    if (rd_vld_p1) payload_p1 <= data_in;
  end

  spi_byte_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .load       (sh_load),
    .load_data  (sh_data),
    .byte_done  (byte_done),
    .bit0_start (bit0_start),
    .sck        (SPI_SCK),
    .di         (SPI_DI)
  );

  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_GAP) && (phase_cnt == GAP_LAST);
  assign SPI_SS3 = !((state == ST_SETUP) || (state == ST_SHIFT) || (state == ST_HOLD));

endmodule

// File: tb/tb_osd_spi_master.sv
module tb_osd_spi_master;

  localparam int LB = 256;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic       reset;
  logic [1:0] op;
  logic [3:0] line;
  logic       req_a, req_b;
  logic       busy_a, done_a, rd_a, sck_a, ss_a, di_a;
  logic       busy_b, done_b, rd_b, sck_b, ss_b, di_b;
  logic [7:0] addr_a, addr_b, din_a, din_b;

  osd_spi_master #(.CLK_DIV(4), .LINE_BYTES(LB), .SS_SETUP(2), .SS_HOLD(2), .SS_GAP(4)) u_dut_a (
    .clk_sys(clk_sys), .reset(reset), .req(req_a), .op(op), .line(line),
    .busy(busy_a), .done(done_a), .data_rd(rd_a), .data_addr(addr_a), .data_in(din_a),
    .SPI_SCK(sck_a), .SPI_SS3(ss_a), .SPI_DI(di_a));

  osd_spi_master #(.CLK_DIV(1), .LINE_BYTES(LB), .SS_SETUP(1), .SS_HOLD(1), .SS_GAP(1)) u_dut_b (
    .clk_sys(clk_sys), .reset(reset), .req(req_b), .op(op), .line(line),
    .busy(busy_b), .done(done_b), .data_rd(rd_b), .data_addr(addr_b), .data_in(din_b),
    .SPI_SCK(sck_b), .SPI_SS3(ss_b), .SPI_DI(di_b));

  // bitmap RAM model: data one cycle after the strobe, junk otherwise
  logic [7:0] mem [LB];
  initial forever begin
    @(posedge clk_sys);
    din_a <= rd_a ? mem[addr_a] : 8'($urandom);
    din_b <= rd_b ? mem[addr_b] : 8'($urandom);
  end

  // observed instance
  bit         sel;
  int         cfg_d, cfg_setup, cfg_hold, cfg_gap;
  logic       m_sck, m_ss, m_di, m_busy, m_done, m_rd;
  logic [7:0] m_addr;
  assign m_sck  = sel ? sck_b  : sck_a;
  assign m_ss   = sel ? ss_b   : ss_a;
  assign m_di   = sel ? di_b   : di_a;
  assign m_busy = sel ? busy_b : busy_a;
  assign m_done = sel ? done_b : done_a;
  assign m_rd   = sel ? rd_b   : rd_a;
  assign m_addr = sel ? addr_b : addr_a;

  int n_tests, n_fail;
  bit mark;
  int cyc, n_busy, n_ss_low, n_done, done_cyc, n_rise, first_rise, last_rise;
  int gap_err, proto_err, n_rd, rd_bad, nb;
  logic [7:0] sh;
  logic [7:0] rxq[$];
  logic [7:0] exp_q[$];
  logic prev_sck, prev_di;

  task automatic clear_stats();
    cyc = 0; n_busy = 0; n_ss_low = 0; n_done = 0; done_cyc = -1; n_rise = 0;
    first_rise = -1; last_rise = 0; gap_err = 0; proto_err = 0; n_rd = 0; rd_bad = 0;
    nb = 0; sh = 8'h00; rxq.delete();
  endtask

  // Protocol monitor: reassembles bytes at SCK rising edges and records timing
  // relative to the cycle after the marked request.
  initial begin
    clear_stats();
    prev_sck = 1'b0;
    prev_di  = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (mark) begin
        clear_stats();
      end else begin
        cyc++;
        if (m_busy) n_busy++;
        if (!m_ss) n_ss_low++;
        if (m_done) begin n_done++; done_cyc = cyc; end
        if (m_sck && m_ss) proto_err++;
        if (m_sck && prev_sck && (m_di != prev_di)) proto_err++;
        if (m_sck && !prev_sck) begin
          if (n_rise == 0) first_rise = cyc;
          else if (cyc - last_rise != 2 * cfg_d) gap_err++;
          last_rise = cyc;
          n_rise++;
          sh = {sh[6:0], m_di};
          nb++;
          if (nb == 8) begin rxq.push_back(sh); nb = 0; end
        end
        if (m_rd) begin
          if (m_addr != 8'(n_rd) || cyc != cfg_setup + 1 + n_rd * 16 * cfg_d) rd_bad++;
          n_rd++;
        end
      end
      prev_sck = m_sck;
      prev_di  = m_di;
    end
  end

  task automatic check(input string name, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_sys);
    #2;
  endtask

  task automatic select(input bit b);
    sel = b;
    cfg_d     = b ? 1 : 4;
    cfg_setup = b ? 1 : 2;
    cfg_hold  = b ? 1 : 2;
    cfg_gap   = b ? 1 : 4;
  endtask

  task automatic drive_req(input logic [1:0] o, input logic [3:0] l, input bit do_mark);
    op = o; line = l; mark = do_mark;
    if (sel) req_b = 1'b1; else req_a = 1'b1;
    @(posedge clk_sys);
    #2;
    req_a = 1'b0; req_b = 1'b0; mark = 1'b0;
  endtask

  task automatic build_exp(input logic [1:0] o, input logic [3:0] l);
    exp_q.delete();
    case (o)
      2'd0:    exp_q.push_back(8'h40);
      2'd1:    exp_q.push_back(8'h41);
      default: exp_q.push_back(8'h20 | {4'h0, l});
    endcase
    if (o == 2'd2) for (int i = 0; i < LB; i++) exp_q.push_back(mem[i]);
  endtask

  function automatic int tx_len(input int nbytes);
    return cfg_setup + nbytes * 16 * cfg_d + cfg_hold + cfg_gap;
  endfunction

  task automatic check_tx(input string tag, input int nbytes);
    int total, bad, lim, b0;
    total = tx_len(nbytes);
    bad = 0;
    check({tag, "_done_cnt"}, n_done, 1);
    check({tag, "_done_cyc"}, done_cyc, total);
    check({tag, "_busy_cycles"}, n_busy, total);
    check({tag, "_ss_low_cycles"}, n_ss_low, total - cfg_gap);
    check({tag, "_sck_rises"}, n_rise, nbytes * 8);
    check({tag, "_first_rise"}, first_rise, cfg_setup + cfg_d + 1);
    check({tag, "_sck_gaps"}, gap_err, 0);
    check({tag, "_protocol"}, proto_err, 0);
    check({tag, "_nbytes"}, rxq.size(), exp_q.size());
    b0 = (rxq.size() > 0) ? int'(rxq[0]) : -1;
    check({tag, "_cmd_byte"}, b0, int'(exp_q[0]));
    lim = (rxq.size() < exp_q.size()) ? rxq.size() : exp_q.size();
    for (int i = 0; i < lim; i++) if (rxq[i] != exp_q[i]) bad++;
    check({tag, "_bad_bytes"}, bad, 0);
    check({tag, "_rd_count"}, n_rd, nbytes - 1);
    check({tag, "_rd_order_timing"}, rd_bad, 0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy_cycles"}, n_busy, 0);
    check({tag, "_ss_low_cycles"}, n_ss_low, 0);
    check({tag, "_done_cnt"}, n_done, 0);
    check({tag, "_sck_rises"}, n_rise, 0);
  endtask

  typedef struct {
    logic [1:0] op;
    logic [3:0] line;
    bit         tx;
    logic [7:0] cmd;
  } vec_t;

  vec_t vecs [5];

  initial begin
    n_tests = 0; n_fail = 0;
    mark = 1'b0; req_a = 1'b0; req_b = 1'b0; op = 2'd0; line = 4'd0; reset = 1'b1;
    select(1'b0);
    vecs[0] = '{2'd1, 4'd0,  1'b1, 8'h41};
    vecs[1] = '{2'd0, 4'd0,  1'b1, 8'h40};
    vecs[2] = '{2'd3, 4'd7,  1'b0, 8'h00};
    vecs[3] = '{2'd1, 4'd15, 1'b1, 8'h41};
    vecs[4] = '{2'd0, 4'd9,  1'b1, 8'h40};

    repeat (3) @(posedge clk_sys);
    #2;
    check("rst_ss3", ss_a, 1);
    check("rst_sck", sck_a, 0);
    check("rst_di", di_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_data_rd", rd_a, 0);
    check("rst_data_addr", addr_a, 0);
    check("rst_ss3_fast", ss_b, 1);
    reset = 1'b0;
    cycles(2);

    // table-driven short commands, including the reserved op
    for (int i = 0; i < 5; i++) begin
      drive_req(vecs[i].op, vecs[i].line, 1'b1);
      exp_q.delete();
      exp_q.push_back(vecs[i].cmd);
      cycles(vecs[i].tx ? 80 : 100);
      if (vecs[i].tx) check_tx($sformatf("vec%0d", i), 1);
      else            check_quiet($sformatf("vec%0d", i));
    end

    // second request while busy must be dropped
    drive_req(2'd1, 4'd0, 1'b1);
    cycles(29);
    drive_req(2'd0, 4'd0, 1'b0);
    cycles(50);
    build_exp(2'd1, 4'd0);
    check_tx("busy_rej", 1);
    drive_req(2'd0, 4'd0, 1'b1);
    cycles(80);
    build_exp(2'd0, 4'd0);
    check_tx("after_rej", 1);

    // full line write at default timing
    for (int i = 0; i < LB; i++) mem[i] = 8'(i) ^ 8'h5A;
    build_exp(2'd2, 4'd5);
    drive_req(2'd2, 4'd5, 1'b1);
    cycles(tx_len(LB + 1) + 10);
    check_tx("write_line", LB + 1);

    // reset in the middle of a line write
    drive_req(2'd2, 4'd3, 1'b1);
    cycles(4999);
    check("pre_reset_busy", busy_a, 1);
    reset = 1'b1;
    @(posedge clk_sys);
    #2;
    check("midrst_ss3", ss_a, 1);
    check("midrst_sck", sck_a, 0);
    check("midrst_busy", busy_a, 0);
    check("midrst_done", done_a, 0);
    reset = 1'b0;
    cycles(40);
    check("midrst_no_done", n_done, 0);
    check("midrst_ss3_idle", ss_a, 1);
    drive_req(2'd1, 4'd0, 1'b1);
    build_exp(2'd1, 4'd0);
    cycles(80);
    check_tx("post_reset_enable", 1);

    // randomized short commands
    for (int k = 0; k < 6; k++) begin
      int r;
      logic [1:0] o;
      logic [3:0] l;
      r = $urandom_range(0, 2);
      o = (r == 2) ? 2'd3 : 2'(r);
      l = 4'($urandom);
      build_exp(o, l);
      drive_req(o, l, 1'b1);
      cycles(100);
      if (o == 2'd3) check_quiet($sformatf("rand%0d", k));
      else           check_tx($sformatf("rand%0d", k), 1);
    end

    // minimum-timing instance: back-to-back bytes with random payloads
    select(1'b1);
    drive_req(2'd1, 4'd0, 1'b1);
    build_exp(2'd1, 4'd0);
    cycles(30);
    check_tx("fast_enable", 1);
    for (int k = 0; k < 2; k++) begin
      logic [3:0] l;
      l = 4'($urandom);
      for (int i = 0; i < LB; i++) mem[i] = 8'($urandom);
      build_exp(2'd2, l);
      drive_req(2'd2, l, 1'b1);
      cycles(tx_len(LB + 1) + 10);
      check_tx($sformatf("fast_write%0d", k), LB + 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
